key_frame_input: RTL and testbench
==================================

Name: key_frame_input

Overview:
- Memory-mapped input peripheral that the CPU reads over the same addr/wdata/we data bus used by the VGA register block.
- Debounces the flap push-button and latches each press as a sticky event.
- Synchronises the VGA vsync into the CPU clock domain and counts frames, so game code can pace itself and poll for flaps.
- Decodes region addr[31:28]=4'b0010. Read data goes to the CPU load mux.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of consecutive stable clk cycles required before the debounced button level changes.
- CNT_W, 20: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  CPU clock; all state in this domain.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  CPU data address.
- wdata  in  32  CPU store data.
- we  in  1  CPU store strobe.
- btn  in  1  raw asynchronous push-button, high = pressed.
- vs  in  1  vsync from the clk25 domain, active-low pulse.
- ena  out  1  region select: addr[31:28]==4'b0010; combinational, independent of we.
- Keyout  out  32  combinational read data.

Behaviour:
- Register map, offset is addr[15:0]:
  - 0x0000 STATUS (R): bit0 flap_pend, bit1 btn_db (debounced level), bit2 frame_pend, bits[31:3]=0.
  - 0x0004 FRAME_CNT (R): 32-bit frame count.
  - 0x0008 FLAP_CNT (R): 32-bit accepted-press count.
  - 0x000C CLEAR (W): write-1-to-clear. wdata[0] clears flap_pend; wdata[1] clears frame_pend. Reads return 0.
  - Any other offset: Keyout=32'h0000_0000. Keyout is also 0 when ena=0.
- Writes to 0x0000, 0x0004 and 0x0008 are ignored. A store takes effect on the clk edge where we & ena & offset==0x000C.
- Synchronisers: btn and vs each pass through a 2-flop synchroniser, then one history flop for edge detection.
  - Frame tick = falling edge of synchronised vs, i.e. one-cycle pulse 3 clk after vs falls.
- Debounce FSM (btn_db is registered):
  - IDLE_LO: btn_db=0. Counter held at 0. If btn_s=1, go to WAIT_HI.
  - WAIT_HI: counter increments each cycle while btn_s=1. If btn_s=0, go to IDLE_LO and zero the counter. When counter==DEBOUNCE_CYCLES-1, go to PRESSED, set btn_db=1, zero the counter, and issue a one-cycle press pulse.
  - PRESSED: btn_db=1. If btn_s=0, go to WAIT_LO.
  - WAIT_LO: counter increments while btn_s=0. If btn_s=1, go to PRESSED and zero the counter. When counter==DEBOUNCE_CYCLES-1, go to IDLE_LO and set btn_db=0.
  - Net effect: a press is reported DEBOUNCE_CYCLES+2 clk after a clean btn rise. The release produces no event.
- Press pulse: sets flap_pend and increments FLAP_CNT.
- Frame tick: sets frame_pend and increments FRAME_CNT.
- Counters wrap from 0xFFFF_FFFF to 0 with no saturation.
- Simultaneous set and clear of the same pending bit in one cycle: set wins, bit stays 1. The counter still increments.
- Clearing one pending bit leaves the other untouched.
- Reset values: FSM=IDLE_LO, btn_db=0, debounce counter=0, flap_pend=0, frame_pend=0, FRAME_CNT=0, FLAP_CNT=0, synchroniser and history flops=1 for vs and 0 for btn.
  - These flop values ensure no spurious tick or press is generated in the first cycles after reset.
- Reset asserted mid-debounce: FSM returns to IDLE_LO on the next edge and the partial count is discarded. After release, a held button needs a full DEBOUNCE_CYCLES again.
- Keyout and ena are purely combinational, so the CPU sees a register value updated on edge N in the same cycle after edge N.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then read 0x20000000, 0x20000004 and 0x20000008 -> all 0. ena=1 for each; ena=0 for addr 0x10000000.
- Hold btn=1 for 10 cycles -> exactly one press. STATUS=0x3 at cycle 6 after the rise (not earlier), FLAP_CNT=1. Release for 10 cycles -> STATUS=0x1, FLAP_CNT still 1.
- Bounce btn high 3 cycles / low 1, repeated 5 times, then low -> STATUS bit0=0, FLAP_CNT=0.
- Drive vs low 20 cycles 5 times -> FRAME_CNT=5, STATUS bit2=1. Store 0x2 to 0x2000000C -> STATUS bit2=0, bit0 unchanged.
- Force FRAME_CNT=0xFFFFFFFF via a preceding tick sequence (or force), then one vs fall -> FRAME_CNT=0. Clear frame_pend on the same cycle as the tick -> frame_pend reads 1.
- Assert rst in WAIT_HI after 2 cycles of btn=1 with btn held -> press reported 6 cycles after rst deasserts, FLAP_CNT=1. A store to 0x20000004 has no effect on FRAME_CNT.

Source files
------------

// File: rtl/key_frame_input_if.sv
// CPU data-bus view of the key/frame input peripheral: address, store data and
// strobe from the CPU; region select and combinational read data back to it.
interface key_frame_input_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        ena;
  logic [31:0] Keyout;

  modport master (output addr, output wdata, output we, input ena, input Keyout);
  modport slave  (input addr, input wdata, input we, output ena, output Keyout);
endinterface

// File: rtl/key_frame_input.sv
// Flap button debouncer with sticky press flag, vsync frame counter, and the
// memory-mapped register window (region 0x2xxx_xxxx) the CPU polls them through.
module key_frame_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  key_frame_input_if.slave   bus,
  input  logic               btn,
  input  logic               vs
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, PRESSED, WAIT_LO} db_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] OFS_STATUS    = 16'h0000;
  localparam logic [15:0] OFS_FRAME_CNT = 16'h0004;
  localparam logic [15:0] OFS_FLAP_CNT  = 16'h0008;
  localparam logic [15:0] OFS_CLEAR     = 16'h000C;

  logic btn_m, btn_s;
  logic vs_m, vs_s, vs_h;
  logic frame_tick;

  db_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             btn_db;
  logic             press;

  logic             flap_pend, frame_pend;
  logic [31:0]      frame_cnt, flap_cnt;

  logic [15:0]      offset;
  logic             wr_clear;
  logic [31:0]      keyout;
  logic             unused_bits;

  // vs idles high, so its flops reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      vs_m  <= 1'b1;
      vs_s  <= 1'b1;
      vs_h  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      btn_m <= btn;
      btn_s <= btn_m;
      vs_m  <= vs;
      vs_s  <= vs_m;
      vs_h  <= vs_s;
    end
  end

  assign frame_tick = vs_h & ~vs_s;

  // Debounce FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE_LO;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      btn_db <= (state_next == PRESSED) || (state_next == WAIT_LO);
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

  // The cycle that leaves IDLE_LO/PRESSED is the first stable sample, so a
  // transition fires as the count would reach DEBOUNCE_CYCLES-1.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE_LO: begin
        cnt_next = '0;
        if (btn_s) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        cnt_next = '0;
        if (!btn_s) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  // Debounce FSM: outputs
  always_comb begin
    press = 1'b0;
    if ((state == WAIT_HI) && btn_s && (cnt_inc == CNT_LAST)) press = 1'b1;
  end

  assign offset   = bus.addr[15:0];
  assign bus.ena  = (bus.addr[31:28] == 4'b0010);
  assign wr_clear = bus.we && bus.ena && (offset == OFS_CLEAR);

  // A set in the same cycle as its clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      flap_pend  <= 1'b0;
      frame_pend <= 1'b0;
      flap_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      flap_pend  <= press      | (flap_pend  & ~(wr_clear & bus.wdata[0]));
      frame_pend <= frame_tick | (frame_pend & ~(wr_clear & bus.wdata[1]));
      if (press)      flap_cnt  <= flap_cnt + 32'd1;
      if (frame_tick) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  always_comb begin
    keyout = '0;
    if (bus.ena) begin
      case (offset)
        OFS_STATUS:    keyout = {29'b0, frame_pend, btn_db, flap_pend};
        OFS_FRAME_CNT: keyout = frame_cnt;
        OFS_FLAP_CNT:  keyout = flap_cnt;
        default:       keyout = '0;
      endcase
    end
  end

  assign bus.Keyout = keyout;

  assign unused_bits = ^{bus.addr[27:16], bus.wdata[31:2]};

endmodule

// File: tb/tb_key_frame_input.sv
// Directed bench for key_frame_input with DEBOUNCE_CYCLES=4: reads queue their
// expected value, and a monitor compares each one as the read is presented.
module tb_key_frame_input;

  localparam logic [31:0] A_STATUS = 32'h2000_0000;
  localparam logic [31:0] A_FRAME  = 32'h2000_0004;
  localparam logic [31:0] A_FLAP   = 32'h2000_0008;
  localparam logic [31:0] A_CLEAR  = 32'h2000_000C;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic vs;
  logic rd_req = 1'b0;

  key_frame_input_if bus();

  key_frame_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .btn (btn),
    .vs  (vs)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ena;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every presented read pops one expectation.
  always @(negedge rd_req) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected read: got 0x%08h, expected no read", bus.Keyout);
    end else begin
      e = exp_q.pop_front();
      check(e.name, bus.Keyout, e.data);
      check({e.name, " ena"}, {31'b0, bus.ena}, {31'b0, e.ena});
    end
  end

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] d,
                    input logic en = 1'b1);
    bus.addr = a;
    bus.we   = 1'b0;
    exp_q.push_back('{name: name, data: d, ena: en});
    rd_req = 1'b1;
    #1 rd_req = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    step(1);
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    btn       = 1'b0;
    vs        = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset state and region decode
    rd(A_STATUS, "reset STATUS", 32'h0);
    rd(A_FRAME,  "reset FRAME_CNT", 32'h0);
    rd(A_FLAP,   "reset FLAP_CNT", 32'h0);
    step(1);
    rd(32'h1000_0000, "other region", 32'h0, 1'b0);
    rd(32'h2000_0010, "unmapped offset", 32'h0);
    rd(A_CLEAR,       "CLEAR readback", 32'h0);

    // Clean press: btn seen by edges 1..6, press lands on edge 6
    btn = 1'b1;
    step(5);
    rd(A_STATUS, "press edge5 STATUS", 32'h0);
    step(1);
    rd(A_STATUS, "press edge6 STATUS", 32'h3);
    rd(A_FLAP,   "press FLAP_CNT", 32'h1);
    step(4);
    btn = 1'b0;
    step(10);
    rd(A_STATUS, "release STATUS", 32'h1);
    rd(A_FLAP,   "release FLAP_CNT", 32'h1);

    // Five vsync pulses
    for (int i = 0; i < 5; i++) begin
      vs = 1'b0;
      step(20);
      vs = 1'b1;
      step(5);
    end
    rd(A_FRAME,  "5 frames FRAME_CNT", 32'd5);
    rd(A_STATUS, "5 frames STATUS", 32'h5);
    wr(A_CLEAR, 32'h2);
    rd(A_STATUS, "clear frame STATUS", 32'h1);

    // Counter wrap, with a frame clear on the same edge as the tick
    force dut.frame_cnt = 32'hFFFF_FFFF;
    #1 release dut.frame_cnt;
    rd(A_FRAME, "preset FRAME_CNT", 32'hFFFF_FFFF);
    vs = 1'b0;
    step(2);
    wr(A_CLEAR, 32'h2);
    rd(A_FRAME,  "wrap FRAME_CNT", 32'h0);
    rd(A_STATUS, "set beats clear STATUS", 32'h5);
    vs = 1'b1;
    step(5);
    wr(A_CLEAR, 32'h1);
    rd(A_STATUS, "clear flap STATUS", 32'h4);

    // Bouncing button never settles long enough
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      step(3);
      btn = 1'b0;
      step(1);
    end
    step(10);
    rd(A_STATUS, "bounce STATUS", 32'h0);
    rd(A_FLAP,   "bounce FLAP_CNT", 32'h0);

    // Reset while in WAIT_HI with the button held: full debounce again
    btn = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    rd(A_STATUS, "post-rst edge5 STATUS", 32'h0);
    step(1);
    rd(A_STATUS, "post-rst edge6 STATUS", 32'h3);
    rd(A_FLAP,   "post-rst FLAP_CNT", 32'h1);

    // Stores outside CLEAR are ignored
    wr(A_FRAME, 32'hDEAD_BEEF);
    rd(A_FRAME, "write FRAME_CNT ignored", 32'h0);
    wr(A_FLAP, 32'h1234_5678);
    rd(A_FLAP, "write FLAP_CNT ignored", 32'h1);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, "write STATUS ignored", 32'h3);

    btn = 1'b0;
    step(2);
    check("expectations drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
